// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback types, sizes and the redirect order test
package wb_arbiter_pkg;
  localparam int NFU = 3;
  localparam int EWD = 4;
  localparam int WBW = 4;
  localparam int OPSZ = 64;
  localparam int PRW = 7;
  localparam int RRW = $clog2(NFU);
  localparam int NSW = $clog2(WBW + 1);
  localparam int WIX = $clog2(WBW);
  typedef struct packed {
    logic [15:0] opid;
    logic [PRW-1:0] prda;
    logic [63:0] prdv;
    logic [7:0] cause;
  } exe_bundle_t;
  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] topid;
  } red_bundle_t;
  function automatic logic op_younger(input logic [15:0] opid, input red_bundle_t redir, input int opsz);
    logic [15:0] m, d_op, d_r;
    m = 16'(opsz - 1);
    d_op = (opid - redir.topid) & m;
    d_r = (redir.opid - redir.topid + 16'd1) & m;
    return d_op >= d_r;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: unit, redirect, commit and PRF signals around the writeback arbiter
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;
  red_bundle_t redir;
  logic stall;
  exe_bundle_t [NFU-1:0][EWD-1:0] exe;
  logic [NFU-1:0][EWD-1:0] claim;
  exe_bundle_t [WBW-1:0] wb;
  logic [WBW-1:0] pwena;
  logic [WBW-1:0][PRW-1:0] pwaddr;
  logic [WBW-1:0][63:0] pwdata;
  logic [31:0] nsquash;
  modport master (output redir, stall, exe, input claim, wb, pwena, pwaddr, pwdata, nsquash);
  modport slave (input redir, stall, exe, output claim, wb, pwena, pwaddr, pwdata, nsquash);
endinterface

// File: rtl/wb_arbiter_select.sv
// wb_select: round-robin prefix claim of up to WBW results, squash flagging and survivor compaction
module wb_select
  import wb_arbiter_pkg::*;
(
  input  logic [RRW-1:0] rr,
  input  logic en,
  input  exe_bundle_t [NFU-1:0][EWD-1:0] exe,
  input  red_bundle_t redir,
  output logic [NFU-1:0][EWD-1:0] claim,
  output exe_bundle_t [WBW-1:0] list,
  output logic [NSW-1:0] nsq,
  output logic any,
  output logic [RRW-1:0] last
);
  always_comb begin
    int taken;
    logic [WIX-1:0] nfwd;
    logic [RRW-1:0] u;
    logic run;
    claim = '0;
    list = '0;
    nsq = '0;
    any = 1'b0;
    last = rr;
    taken = 0;
    nfwd = '0;
    u = '0;
    run = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      u = RRW'((int'(rr) + i) % NFU);
      run = en;
      for (int s = 0; s < EWD; s++) begin
        run = run && exe[u][s].opid[15] && taken < WBW;
        if (run) begin
          claim[u][s] = 1'b1;
          taken++;
          any = 1'b1;
          last = u;
          if (redir.opid[15] && op_younger(exe[u][s].opid, redir, OPSZ)) nsq = nsq + NSW'(1);
          else begin
            list[nfwd] = exe[u][s];
            nfwd = nfwd + WIX'(1);
          end
        end
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage registering claimed results and driving commit and PRF write ports
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  wb_arbiter_if.slave bus
);
  exe_bundle_t [WBW-1:0] wb_q, wb_d, list;
  logic [WBW-1:0] wr_q;
  logic [RRW-1:0] rr_q, rr_d, last;
  logic [31:0] nsq_q, nsq_d;
  logic [NSW-1:0] nsel, nheld;
  logic [32:0] sum;
  logic any;
  wb_select u_sel (
    .rr(rr_q),
    .en(!rst && !bus.stall),
    .exe(bus.exe),
    .redir(bus.redir),
    .claim(bus.claim),
    .list(list),
    .nsq(nsel),
    .any(any),
    .last(last)
  );
  always_comb begin
    wb_d = bus.stall ? wb_q : list;
    nheld = '0;
    for (int k = 0; k < WBW; k++)
      if (bus.stall && wb_q[k].opid[15] && bus.redir.opid[15] && op_younger(wb_q[k].opid, bus.redir, OPSZ)) begin
        wb_d[k].opid = '0;
        nheld = nheld + NSW'(1);
      end
    sum = {1'b0, nsq_q} + 33'(bus.stall ? nheld : nsel);
    nsq_d = sum[32] ? '1 : sum[31:0];
    rr_d = !any ? rr_q : (last == RRW'(NFU - 1)) ? '0 : last + RRW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
      wr_q <= '0;
      rr_q <= '0;
      nsq_q <= '0;
    end else begin
      wb_q <= wb_d;
      wr_q <= {WBW{bus.stall}};
      rr_q <= rr_d;
      nsq_q <= nsq_d;
    end
  end
  for (genvar k = 0; k < WBW; k++) begin : g_prf
    assign bus.pwena[k] = !rst && !wr_q[k] && wb_q[k].opid[15] && wb_q[k].prda != '0 && !wb_q[k].cause[7];
    assign bus.pwaddr[k] = wb_q[k].prda;
    assign bus.pwdata[k] = wb_q[k].prdv;
  end
  assign bus.wb = wb_q;
  assign bus.nsquash = nsq_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  wb_arbiter_if bus ();
  wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exe_bundle_t m_wb [WBW];
  int m_age [WBW];
  int m_rr = 0;
  longint m_nsq = 0;
  logic [NFU-1:0][EWD-1:0] e_claim;
  exe_bundle_t e_fwd [$];
  int e_add, e_last, e_n;
  function automatic exe_bundle_t mk(logic [15:0] op, logic [PRW-1:0] pa, logic [63:0] pv, logic [7:0] c);
    exe_bundle_t e;
    e.opid = op;
    e.prda = pa;
    e.prdv = pv;
    e.cause = c;
    return e;
  endfunction
  function automatic bit younger(logic [15:0] op, red_bundle_t r);
    return r.opid[15] && (((int'(op) - int'(r.topid)) & (OPSZ - 1)) >= ((int'(r.opid) - int'(r.topid) + 1) & (OPSZ - 1)));
  endfunction
  function automatic void model_comb();
    int cu[$];
    int cs[$];
    e_claim = '0;
    e_fwd = {};
    e_add = 0;
    e_n = 0;
    e_last = m_rr;
    if (!rst && bus.stall) begin
      for (int k = 0; k < WBW; k++)
        if (m_wb[k].opid[15] && younger(m_wb[k].opid, bus.redir)) e_add++;
    end else if (!rst) begin
      for (int i = 0; i < NFU; i++) begin
        int u = (m_rr + i) % NFU;
        for (int s = 0; s < EWD; s++) begin
          if (!bus.exe[u][s].opid[15]) break;
          cu.push_back(u);
          cs.push_back(s);
        end
      end
      e_n = cu.size() < WBW ? cu.size() : WBW;
      for (int j = 0; j < e_n; j++) begin
        e_claim[cu[j]][cs[j]] = 1'b1;
        e_last = cu[j];
        if (younger(bus.exe[cu[j]][cs[j]].opid, bus.redir)) e_add++;
        else e_fwd.push_back(bus.exe[cu[j]][cs[j]]);
      end
    end
  endfunction
  function automatic void model_commit();
    if (rst) begin
      for (int k = 0; k < WBW; k++) begin
        m_wb[k] = '0;
        m_age[k] = 0;
      end
      m_rr = 0;
      m_nsq = 0;
    end else begin
      for (int k = 0; k < WBW; k++) begin
        if (bus.stall) begin
          if (m_wb[k].opid[15] && younger(m_wb[k].opid, bus.redir)) m_wb[k].opid = '0;
          m_age[k]++;
        end else begin
          if (k < e_fwd.size()) m_wb[k] = e_fwd[k];
          else m_wb[k] = '0;
          m_age[k] = 0;
        end
      end
      if (!bus.stall && e_n > 0) m_rr = (e_last + 1) % NFU;
      m_nsq = m_nsq + e_add;
      if (m_nsq > 64'hFFFF_FFFF) m_nsq = 64'hFFFF_FFFF;
    end
  endfunction
  function automatic logic [WBW-1:0] exp_pwena();
    logic [WBW-1:0] p;
    for (int k = 0; k < WBW; k++)
      p[k] = !rst && m_age[k] == 0 && m_wb[k].opid[15] && m_wb[k].prda != '0 && !m_wb[k].cause[7];
    return p;
  endfunction
  task automatic clk_step();
    model_comb();
    @(posedge clk);
    model_commit();
    #1;
  endtask
  task automatic fill_all();
    for (int u = 0; u < NFU; u++)
      for (int s = 0; s < EWD; s++)
        bus.exe[u][s] = mk(16'(32'h8000 + 16 * u + s), PRW'(u * 4 + s + 1), 64'(u * 100 + s), 8'h00);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redir = '0;
    bus.exe = '0;
    clk_step();
    fill_all();
    #1;
    checks++;
    if (bus.claim !== '0) begin errs++; $display("FAIL reset_claim: got %h expected 0", bus.claim); end
    clk_step();
    rst = 1'b0;
    bus.exe = '0;
    for (int n = 0; n < 5; n++) begin
      clk_step();
      checks++;
      if (bus.wb !== '0) begin errs++; $display("FAIL idle_wb: got %h expected 0", bus.wb); end
      checks++;
      if (bus.claim !== '0) begin errs++; $display("FAIL idle_claim: got %h expected 0", bus.claim); end
      checks++;
      if (bus.pwena !== '0) begin errs++; $display("FAIL idle_pwena: got %b expected 0", bus.pwena); end
      checks++;
      if (bus.nsquash !== 32'd0) begin errs++; $display("FAIL idle_nsquash: got %0d expected 0", bus.nsquash); end
    end
  endtask
  task automatic test_claim();
    logic [15:0] exp_op [WBW];
    exp_op = '{16'h8000, 16'h8001, 16'h8002, 16'h8010};
    bus.exe = '0;
    for (int u = 0; u < NFU; u++)
      for (int s = 0; s < 3; s++)
        bus.exe[u][s] = mk(16'(32'h8000 + 16 * u + s), PRW'(u * 4 + s + 1), 64'(u * 100 + s), 8'h00);
    #1;
    checks++;
    if (bus.claim !== 12'h017) begin errs++; $display("FAIL claim_three_each: got %h expected 017", bus.claim); end
    clk_step();
    bus.exe = '0;
    for (int k = 0; k < WBW; k++) begin
      checks++;
      if (bus.wb[k].opid !== exp_op[k]) begin errs++; $display("FAIL claim_wb%0d: got %h expected %h", k, bus.wb[k].opid, exp_op[k]); end
    end
    fill_all();
    #1;
    checks++;
    if (bus.claim !== 12'hF00) begin errs++; $display("FAIL rr_after_claim: got %h expected f00", bus.claim); end
    clk_step();
    bus.exe = '0;
  endtask
  task automatic test_hole();
    bus.exe = '0;
    bus.exe[0][0] = mk(16'h8030, 7'd3, 64'h30, 8'h00);
    bus.exe[0][2] = mk(16'h8032, 7'd4, 64'h32, 8'h00);
    #1;
    checks++;
    if (bus.claim !== 12'h001) begin errs++; $display("FAIL hole_claim: got %h expected 001", bus.claim); end
    clk_step();
    bus.exe = '0;
    checks++;
    if (bus.wb[0].opid !== 16'h8030 || bus.wb[1].opid !== 16'h0) begin
      errs++; $display("FAIL hole_wb: got %h %h expected 8030 0000", bus.wb[0].opid, bus.wb[1].opid);
    end
  endtask
  task automatic test_squash();
    bus.redir.opid = 16'h8005;
    bus.redir.topid = 16'h0000;
    bus.exe = '0;
    bus.exe[0][0] = mk(16'h8003, 7'd1, 64'h3, 8'h00);
    bus.exe[0][1] = mk(16'h8006, 7'd2, 64'h6, 8'h00);
    bus.exe[0][2] = mk(16'h8009, 7'd3, 64'h9, 8'h00);
    #1;
    checks++;
    if (bus.claim !== 12'h007) begin errs++; $display("FAIL squash_claim: got %h expected 007", bus.claim); end
    clk_step();
    bus.exe = '0;
    bus.redir = '0;
    checks++;
    if (bus.wb[0].opid !== 16'h8003) begin errs++; $display("FAIL squash_wb0: got %h expected 8003", bus.wb[0].opid); end
    checks++;
    if ({bus.wb[1].opid, bus.wb[2].opid, bus.wb[3].opid} !== 48'h0) begin
      errs++; $display("FAIL squash_rest: got %h %h %h expected 0", bus.wb[1].opid, bus.wb[2].opid, bus.wb[3].opid);
    end
    checks++;
    if (bus.nsquash !== 32'd2) begin errs++; $display("FAIL squash_count: got %0d expected 2", bus.nsquash); end
  endtask
  task automatic test_stall();
    exe_bundle_t ent;
    ent = mk(16'h8010, 7'd7, 64'h1234, 8'h00);
    bus.exe = '0;
    bus.exe[0][0] = ent;
    clk_step();
    bus.stall = 1'b1;
    fill_all();
    #1;
    checks++;
    if (bus.claim !== '0) begin errs++; $display("FAIL stall_claim: got %h expected 0", bus.claim); end
    checks++;
    if (bus.pwena[0] !== 1'b1) begin errs++; $display("FAIL stall_first_write: got %b expected 1", bus.pwena[0]); end
    for (int n = 0; n < 2; n++) begin
      clk_step();
      checks++;
      if (bus.wb[0] !== ent) begin errs++; $display("FAIL stall_hold: got %h expected %h", bus.wb[0], ent); end
      checks++;
      if (bus.pwena[0] !== 1'b0) begin errs++; $display("FAIL stall_rewrite: got %b expected 0", bus.pwena[0]); end
    end
    bus.redir.opid = 16'h8008;
    bus.redir.topid = 16'h0000;
    clk_step();
    checks++;
    if (bus.wb[0].opid !== 16'h0) begin errs++; $display("FAIL stall_squash: got %h expected 0", bus.wb[0].opid); end
    checks++;
    if (bus.nsquash !== 32'd3) begin errs++; $display("FAIL stall_squash_count: got %0d expected 3", bus.nsquash); end
    bus.stall = 1'b0;
    bus.redir = '0;
    bus.exe = '0;
    clk_step();
  endtask
  task automatic test_exception();
    bus.exe = '0;
    bus.exe[0][0] = mk(16'h8020, 7'd5, 64'hAA, 8'h82);
    bus.exe[0][1] = mk(16'h8021, 7'd5, 64'hBB, 8'h00);
    clk_step();
    bus.exe = '0;
    checks++;
    if (bus.wb[0].opid !== 16'h8020 || bus.wb[0].cause !== 8'h82) begin
      errs++; $display("FAIL exc_forward: got %h/%h expected 8020/82", bus.wb[0].opid, bus.wb[0].cause);
    end
    checks++;
    if (bus.pwena[1:0] !== 2'b10) begin errs++; $display("FAIL exc_pwena: got %b expected 10", bus.pwena[1:0]); end
    checks++;
    if (bus.pwaddr[1] !== 7'd5 || bus.pwdata[1] !== 64'hBB) begin
      errs++; $display("FAIL exc_prf: got %0d/%h expected 5/bb", bus.pwaddr[1], bus.pwdata[1]);
    end
  endtask
  task automatic test_fairness();
    int gap [NFU];
    for (int u = 0; u < NFU; u++) gap[u] = 0;
    fill_all();
    for (int n = 0; n < 3 * NFU; n++) begin
      #1;
      model_comb();
      checks++;
      if (bus.claim !== e_claim) begin errs++; $display("FAIL fair_claim: got %h expected %h", bus.claim, e_claim); end
      for (int u = 0; u < NFU; u++) begin
        gap[u] = bus.claim[u] != '0 ? 0 : gap[u] + 1;
        checks++;
        if (gap[u] >= NFU) begin errs++; $display("FAIL fair_starve: unit %0d idle %0d cycles expected < %0d", u, gap[u], NFU); end
      end
      clk_step();
    end
    bus.exe = '0;
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 49) == 0;
      bus.stall = $urandom_range(0, 3) == 0;
      bus.redir.opid = {1'($urandom_range(0, 2) == 0), 15'($urandom)};
      bus.redir.topid = 16'($urandom);
      for (int u = 0; u < NFU; u++)
        for (int s = 0; s < EWD; s++)
          bus.exe[u][s] = $urandom_range(0, 9) < 7 ?
            mk(16'h8000 | 16'($urandom), $urandom_range(0, 3) == 0 ? PRW'(0) : PRW'($urandom),
               {$urandom, $urandom}, $urandom_range(0, 4) == 0 ? 8'h80 | 8'($urandom) : 8'($urandom) & 8'h7f) : '0;
      #1;
      model_comb();
      checks++;
      if (bus.claim !== e_claim) begin errs++; $display("FAIL rand_claim: cycle %0d got %h expected %h", n, bus.claim, e_claim); end
      clk_step();
      for (int k = 0; k < WBW; k++) begin
        checks++;
        if (bus.wb[k] !== m_wb[k]) begin errs++; $display("FAIL rand_wb%0d: cycle %0d got %h expected %h", k, n, bus.wb[k], m_wb[k]); end
      end
      checks++;
      if (bus.pwena !== exp_pwena()) begin errs++; $display("FAIL rand_pwena: cycle %0d got %b expected %b", n, bus.pwena, exp_pwena()); end
      checks++;
      if (bus.nsquash !== 32'(m_nsq)) begin errs++; $display("FAIL rand_nsquash: cycle %0d got %0d expected %0d", n, bus.nsquash, m_nsq); end
    end
    rst = 1'b0;
    bus.stall = 1'b0;
  endtask
  initial begin
    test_reset();
    test_claim();
    test_hole();
    test_squash();
    test_stall();
    test_exception();
    test_fairness();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
